spi_slave_ctrl: RTL

- SPI slave front-end that sequences the single-port command RAM. The RAM takes 10-bit command words: din[9:8] is the opcode, din[7:0] is the payload.
  - 00: write address
  - 01: write data
  - 10: read address
  - 11: read data
- Deserialises MOSI frames into 10-bit rx_data with a one-cycle rx_valid pulse.
- On a read-data frame, waits for the RAM's tx_valid/tx_data and serialises the 8-bit result on MISO.
- Sits between the SPI pins (already synchronous to clk) and the RAM.

---
 rtl/spi_slave_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave front-end that frames 10-bit RAM commands and returns read data on MISO
module spi_slave_ctrl #(
   parameter int CMD_WIDTH   = 10,
   parameter int DATA_WIDTH  = 8,
   parameter int TX_WAIT_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ss_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic [CMD_WIDTH-1:0]  rx_data,
   output logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid
);
   localparam int CW = $clog2((CMD_WIDTH > DATA_WIDTH ? CMD_WIDTH : DATA_WIDTH) + 1);
   localparam int WW = $clog2(TX_WAIT_MAX + 1);

   typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
   logic [CMD_WIDTH-2:0]  shift_q, shift_d;
   logic [DATA_WIDTH-2:0] tx_sh_q, tx_sh_d;
   logic [CMD_WIDTH-1:0]  rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  miso_q, miso_d;
   logic                  rd_addr_done_q, rd_addr_done_d;
   logic [CMD_WIDTH-1:0]  word;

   assign word     = {shift_q, mosi};
   assign miso     = miso_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

   // next-state: ss_n high aborts any active phase; otherwise frame, decode and serialise
   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      wait_cnt_d     = wait_cnt_q;
      shift_d        = shift_q;
      tx_sh_d        = tx_sh_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      miso_d         = 1'b0;
      rd_addr_done_d = rd_addr_done_q;
      if (state_q != IDLE && ss_n) begin
         state_d    = IDLE;
         bit_cnt_d  = '0;
         wait_cnt_d = '0;
         shift_d    = '0;
         tx_sh_d    = '0;
         if (state_q == TX_WAIT || state_q == TX_SHIFT) rd_addr_done_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (!ss_n) state_d = CHK_CMD;
            CHK_CMD: begin
               shift_d   = {shift_q[CMD_WIDTH-3:0], mosi};
               bit_cnt_d = CW'(1);
               state_d   = !mosi ? WRITE : (rd_addr_done_q ? READ_DATA : READ_ADD);
            end
            WRITE, READ_ADD, READ_DATA: begin
               if (bit_cnt_q == CW'(CMD_WIDTH)) begin
                  bit_cnt_d = '0;
                  state_d   = (state_q == READ_DATA && rx_data_q[CMD_WIDTH-1 -: 2] == 2'b11) ? TX_WAIT : DONE;
               end else begin
                  shift_d   = {shift_q[CMD_WIDTH-3:0], mosi};
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == CW'(CMD_WIDTH - 1)) begin
                     rx_data_d  = word;
                     rx_valid_d = 1'b1;
                     if (word[CMD_WIDTH-1 -: 2] == 2'b10) rd_addr_done_d = 1'b1;
                  end
               end
            end
            TX_WAIT: begin
               if (tx_valid) begin
                  tx_sh_d    = tx_data[DATA_WIDTH-2:0];
                  miso_d     = tx_data[DATA_WIDTH-1];
                  bit_cnt_d  = '0;
                  wait_cnt_d = '0;
                  state_d    = TX_SHIFT;
               end else if (wait_cnt_q == WW'(TX_WAIT_MAX - 1)) begin
                  wait_cnt_d     = '0;
                  rd_addr_done_d = 1'b0;
                  state_d        = DONE;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
            TX_SHIFT: begin
               if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                  bit_cnt_d      = '0;
                  rd_addr_done_d = 1'b0;
                  state_d        = DONE;
               end else begin
                  miso_d    = tx_sh_q[DATA_WIDTH-2];
                  tx_sh_d   = tx_sh_q << 1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   // state and registered outputs; async reset aborts any frame immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         bit_cnt_q      <= '0;
         wait_cnt_q     <= '0;
         shift_q        <= '0;
         tx_sh_q        <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         miso_q         <= 1'b0;
         rd_addr_done_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         wait_cnt_q     <= wait_cnt_d;
         shift_q        <= shift_d;
         tx_sh_q        <= tx_sh_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         miso_q         <= miso_d;
         rd_addr_done_q <= rd_addr_done_d;
      end
   end
endmodule
